alu_issue: RTL
==============

# alu_issue

Decode/issue stage feeding the `alu` in the EX stage. Accepts one instruction word per cycle and decodes the opcode into the 3-bit ALU `op`. Selects operand `a`/`b` from register-file read data or a sign-extended immediate. Registers everything into the ID/EX pipeline register, with downstream stall, flush and a one-bubble load-use interlock.

## Interface
- DSIZE, 32 (from define.v): operand/data width
- CNTW, 16: width of the saturating stall counter

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instr holds a valid instruction this cycle
- instr  in  32  instruction word: [31:28] opcode, [27:24] rd, [23:20] rs, [19:16] rt, [15:0] imm16
- issue_ready  out  1  instruction accepted this cycle (combinational)
- rs_addr  out  4  = instr[23:20], register-file read port A (combinational)
- rt_addr  out  4  = instr[19:16], register-file read port B (combinational)
- rs_data  in  DSIZE  register-file read data A, same cycle
- rt_data  in  DSIZE  register-file read data B, same cycle
- ex_stall  in  1  EX stage cannot take a new instruction; hold ID/EX
- flush  in  1  kill the contents of ID/EX (branch/exception redirect)
- ex_valid  out  1  ID/EX holds a live instruction
- ex_op  out  3  ALU op (`ADD/`SUB/`AND/`XOR/`COM/`MUL/`ADDI from define.v)
- ex_a  out  DSIZE  ALU operand a
- ex_b  out  DSIZE  ALU operand b
- ex_rd  out  4  destination register
- ex_wen  out  1  register write enable
- ex_memread  out  1  load
- ex_memwrite  out  1  store
- ex_store_data  out  DSIZE  store data (rt_data)
- illegal  out  1  one-cycle pulse: the instruction accepted last cycle was an undefined opcode
- stall_cnt  out  CNTW  cycles with instr_valid=1 and issue_ready=0, saturating

## Operation
- Opcode map: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 COM, 5 MUL (all R-type, b=rt_data, wen=1); 6 ADDI (op `ADDI, b=sext(imm16), wen=1); 7 LW (op `ADD, b=sext(imm16), wen=1, memread=1); 8 SW (op `ADD, b=sext(imm16), wen=0, memwrite=1, store_data=rt_data); 9 NOP (valid, wen=0). 10–15 are illegal: they load a bubble and pulse `illegal`.
- ex_a = rs_data for every opcode. sext copies imm16[15] into bits DSIZE-1:16.
- rd=0 forces ex_wen=0, because r0 is hardwired zero.
- Load-use hazard (`haz`) is asserted when all of these hold: ex_valid=1, ex_memread=1, ex_rd≠0, and ex_rd matches rs, or ex_rd matches rt for an opcode that reads rt (0–5, 8). NOP and illegal opcodes never hazard.
- State machine:
  - RUN: normal issue. On `haz` go to BUBBLE.
  - BUBBLE: ID/EX gets ex_valid=0, and the instruction is not accepted. Return to RUN next cycle; the waiting instruction then re-evaluates and issues.
- Priority, highest first:
  1. rst: all registers cleared.
  2. flush: ex_valid←0, issue_ready=0, state←RUN.
  3. ex_stall: hold all ex_* and state, issue_ready=0.
  4. haz: enter BUBBLE.
  5. Normal: accept if instr_valid, else load a bubble.
- issue_ready = instr_valid & ~flush & ~ex_stall & ~haz.
- A bubble sets ex_valid=0, ex_wen=0, ex_memread=0, ex_memwrite=0. Data fields are don't-care but are zeroed.
- stall_cnt increments when instr_valid & ~issue_ready and stops at 2^CNTW−1. It is cleared only by rst.

## Timing
- Latency: an instruction accepted on edge N appears on ex_* after edge N, for the cycle N..N+1.
- Load-use costs exactly one bubble cycle; back-to-back LW→dependent→dependent costs one bubble total.
- Reset values: ex_valid 0, ex_op 0, ex_a 0, ex_b 0, ex_rd 0, ex_wen 0, ex_memread 0, ex_memwrite 0, ex_store_data 0, illegal 0, stall_cnt 0, state RUN.
- rst mid-hazard: state returns to RUN and ID/EX clears; no pending instruction is retained (the fetch side re-presents it).
- flush and ex_stall together: flush wins, and ID/EX empties.
- ex_stall during BUBBLE: state holds in BUBBLE; bubble completes after the stall releases.
- `illegal` is registered; it is high for exactly the cycle the illegal bubble occupies ID/EX. It is not raised on flush/stall.

## Test plan
- ADD r3,r1,r2 with rs_data=5, rt_data=7 → next cycle: ex_valid=1, ex_op=`ADD, ex_a=5, ex_b=7, ex_rd=3, ex_wen=1.
- ADDI r4,r1,0xFFFE with rs_data=10 → ex_op=`ADDI, ex_b=0xFFFFFFFE, ex_wen=1. The same instruction with rd=0 → ex_wen=0.
- LW r5 then ADD r6,r5,r2 presented back-to-back:
  - cycle after LW: issue_ready=0, then one cycle ex_valid=0, then ADD issues.
  - stall_cnt=1.
- Hold ex_stall=1 for 3 cycles while instr_valid=1:
  - ex_* is unchanged and issue_ready=0 throughout.
  - stall_cnt+=3.
  - After release, the instruction issues next edge.
- Opcode 0xC → next cycle: ex_valid=0, illegal=1 for one cycle. With flush=1 and ex_stall=1 in the same cycle → ex_valid=0 next cycle.
- Assert rst while in BUBBLE → all outputs at their reset values next cycle. stall_cnt forced to 0xFFFF then one more stall → stays 0xFFFF.

Source files
------------

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - issue-side and ID/EX-side signal bundle for alu_issue
interface alu_issue_if #(
  parameter int DSIZE = 32,
  parameter int CNTW  = 16
);
  logic             instr_valid;
  logic [31:0]      instr;
  logic             issue_ready;
  logic [3:0]       rs_addr;
  logic [3:0]       rt_addr;
  logic [DSIZE-1:0] rs_data;
  logic [DSIZE-1:0] rt_data;
  logic             ex_stall;
  logic             flush;
  logic             ex_valid;
  logic [2:0]       ex_op;
  logic [DSIZE-1:0] ex_a;
  logic [DSIZE-1:0] ex_b;
  logic [3:0]       ex_rd;
  logic             ex_wen;
  logic             ex_memread;
  logic             ex_memwrite;
  logic [DSIZE-1:0] ex_store_data;
  logic             illegal;
  logic [CNTW-1:0]  stall_cnt;

  modport slave (
    input  instr_valid, instr, rs_data, rt_data, ex_stall, flush,
    output issue_ready, rs_addr, rt_addr, ex_valid, ex_op, ex_a, ex_b, ex_rd,
           ex_wen, ex_memread, ex_memwrite, ex_store_data, illegal, stall_cnt
  );

  modport master (
    output instr_valid, instr, rs_data, rt_data, ex_stall, flush,
    input  issue_ready, rs_addr, rt_addr, ex_valid, ex_op, ex_a, ex_b, ex_rd,
           ex_wen, ex_memread, ex_memwrite, ex_store_data, illegal, stall_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode/issue stage with ID/EX register, stall, flush and load-use interlock
module alu_issue #(
  parameter int DSIZE = 32,
  parameter int CNTW  = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_RUN = 1'b0, S_BUBBLE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_ex_valid;
  logic [2:0]       r_ex_op;
  logic [DSIZE-1:0] r_ex_a;
  logic [DSIZE-1:0] r_ex_b;
  logic [3:0]       r_ex_rd;
  logic             r_ex_wen;
  logic             r_ex_memread;
  logic             r_ex_memwrite;
  logic [DSIZE-1:0] r_ex_store_data;
  logic             r_illegal;
  logic [CNTW-1:0]  r_stall_cnt;

  logic [3:0]       w_opc;
  logic [3:0]       w_rd;
  logic [3:0]       w_rs;
  logic [3:0]       w_rt;
  logic [DSIZE-1:0] w_imm_sext;
  logic             w_legal;
  logic             w_nop;
  logic             w_reads_rt;
  logic             w_use_imm;
  logic [2:0]       w_op;
  logic             w_wen;
  logic             w_memread;
  logic             w_memwrite;
  logic [DSIZE-1:0] w_b;
  logic             w_haz;
  logic             w_ready;
  logic             w_load;

  assign w_opc      = bus.instr[31:28];
  assign w_rd       = bus.instr[27:24];
  assign w_rs       = bus.instr[23:20];
  assign w_rt       = bus.instr[19:16];
  assign w_imm_sext = {{(DSIZE-16){bus.instr[15]}}, bus.instr[15:0]};

  always_comb begin
    w_legal    = 1'b1;
    w_nop      = 1'b0;
    w_reads_rt = 1'b0;
    w_use_imm  = 1'b0;
    w_op       = OP_ADD;
    w_wen      = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    case (w_opc)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
        w_op       = w_opc[2:0];
        w_reads_rt = 1'b1;
        w_wen      = 1'b1;
      end
      4'd6: begin
        w_op      = OP_ADDI;
        w_use_imm = 1'b1;
        w_wen     = 1'b1;
      end
      4'd7: begin
        w_use_imm = 1'b1;
        w_wen     = 1'b1;
        w_memread = 1'b1;
      end
      4'd8: begin
        w_use_imm  = 1'b1;
        w_reads_rt = 1'b1;
        w_memwrite = 1'b1;
      end
      4'd9:    w_nop   = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_b = w_use_imm ? w_imm_sext : bus.rt_data;

  // A load in ID/EX whose result feeds this instruction forces one bubble.
  assign w_haz = bus.instr_valid & w_legal & ~w_nop &
                 r_ex_valid & r_ex_memread & (r_ex_rd != 4'd0) &
                 ((r_ex_rd == w_rs) | (w_reads_rt & (r_ex_rd == w_rt)));

  assign w_ready = bus.instr_valid & ~bus.flush & ~bus.ex_stall & ~w_haz;
  assign w_load  = w_ready & w_legal;

  always_comb begin
    w_state_nxt = S_RUN;
    if (bus.flush)         w_state_nxt = S_RUN;
    else if (bus.ex_stall) w_state_nxt = r_state;
    else if (w_haz)        w_state_nxt = S_BUBBLE;
    else                   w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (!bus.flush && !bus.ex_stall && !w_load) || bus.flush) begin
      r_ex_valid      <= 1'b0;
      r_ex_op         <= 3'd0;
      r_ex_a          <= '0;
      r_ex_b          <= '0;
      r_ex_rd         <= 4'd0;
      r_ex_wen        <= 1'b0;
      r_ex_memread    <= 1'b0;
      r_ex_memwrite   <= 1'b0;
      r_ex_store_data <= '0;
    end else if (w_load) begin
      r_ex_valid      <= 1'b1;
      r_ex_op         <= w_op;
      r_ex_a          <= bus.rs_data;
      r_ex_b          <= w_b;
      r_ex_rd         <= w_rd;
      r_ex_wen        <= w_wen & (w_rd != 4'd0);
      r_ex_memread    <= w_memread;
      r_ex_memwrite   <= w_memwrite;
      r_ex_store_data <= bus.rt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_illegal <= w_ready & ~w_legal;
      if (bus.instr_valid && !w_ready && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign bus.issue_ready   = w_ready;
  assign bus.rs_addr       = w_rs;
  assign bus.rt_addr       = w_rt;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_op         = r_ex_op;
  assign bus.ex_a          = r_ex_a;
  assign bus.ex_b          = r_ex_b;
  assign bus.ex_rd         = r_ex_rd;
  assign bus.ex_wen        = r_ex_wen;
  assign bus.ex_memread    = r_ex_memread;
  assign bus.ex_memwrite   = r_ex_memwrite;
  assign bus.ex_store_data = r_ex_store_data;
  assign bus.illegal       = r_illegal;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule
